// File: rtl/sram_bus_master.sv
`timescale 1ns/1ps
// sram_bus_master: initiator for a static-memory bus. Accepts one read or write
// request at a time and sequences chip select, strobes and data around it.
// Each transfer has four phases: setup, strobe, hold, and a turnaround cycle that
// reports completion. The target may stretch the final strobe cycle with nwait.
module sram_bus_master #(
  parameter int AW       = 13,
  parameter int DW       = 8,
  parameter int T_SETUP  = 1,
  parameter int T_STROBE = 3,
  parameter int T_HOLD   = 1,
  parameter int CW       = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rnw,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          ready,
  output logic          done,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic          nwait,
  output logic [AW-1:0] addr,
  inout  wire  [DW-1:0] sram_data,
  output logic          ncs,
  output logic          nwe,
  output logic          noe
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN
  } state_t;

  // Counters load with (cycles - 1) and the phase ends when they reach zero.
  localparam logic [CW-1:0] SETUP_LOAD  = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] STROBE_LOAD = CW'(T_STROBE - 1);
  localparam logic [CW-1:0] HOLD_LOAD   = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            rnw_q;
  logic [DW-1:0]   wdata_q;
  logic            drive_en;

  // Write data reaches the pins only while a write owns the bus; the enable is a
  // register, so there is no combinational path onto the data pins.
  assign sram_data = drive_en ? wdata_q : {DW{1'bz}};

  // Transfer sequencer: every bus control and handshake output is registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      rnw_q    <= 1'b0;
      wdata_q  <= '0;
      drive_en <= 1'b0;
      addr     <= '0;
      ncs      <= 1'b1;
      nwe      <= 1'b1;
      noe      <= 1'b1;
      ready    <= 1'b1;
      done     <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          rd_valid <= 1'b0;
          if (req) begin
            state    <= SETUP;
            cnt      <= SETUP_LOAD;
            rnw_q    <= rnw;
            addr     <= req_addr;
            wdata_q  <= req_wdata;
            drive_en <= !rnw;
            ncs      <= 1'b0;
            ready    <= 1'b0;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= STROBE_LOAD;
            nwe   <= rnw_q;
            noe   <= !rnw_q;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        STROBE: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (nwait) begin
            state <= HOLD;
            cnt   <= HOLD_LOAD;
            nwe   <= 1'b1;
            noe   <= 1'b1;
            if (rnw_q) begin
              rd_data <= sram_data;
            end
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state    <= TURN;
            ncs      <= 1'b1;
            drive_en <= 1'b0;
            done     <= 1'b1;
            rd_valid <= rnw_q;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        TURN: begin
          state    <= IDLE;
          done     <= 1'b0;
          rd_valid <= 1'b0;
          ready    <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          drive_en <= 1'b0;
          ncs      <= 1'b1;
          nwe      <= 1'b1;
          noe      <= 1'b1;
          ready    <= 1'b1;
          done     <= 1'b0;
          rd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
